// File: rtl/ex_div_iter_pkg.sv
// Shared types and constants for the iterative RV64M divider.
// W-variant support is compiled in with EX_DIV_WORD_EN.
package ex_div_iter_pkg;

    localparam int XLEN  = 64;
    localparam int WLEN  = 32;
    localparam int CNT_W = 6;

    localparam logic [XLEN-1:0]  ZERO_DWORD = '0;
    localparam logic [XLEN-1:0]  DMIN       = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  WMIN       = 64'hFFFF_FFFF_8000_0000;
    localparam logic [CNT_W-1:0] CNT_DLAST  = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_WLAST  = CNT_W'(WLEN - 1);

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX,
        DIV_DONE
    } div_state_e;

    typedef struct packed {
        logic [XLEN-1:0] abs_a;
        logic [XLEN-1:0] abs_b;
        logic            q_neg;
        logic            r_neg;
        logic            word;
        logic            special;
        logic [XLEN-1:0] special_res;
    } div_prep_t;

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
    endfunction

endpackage

// File: rtl/ex_div_opprep.sv
// Divider operand prep: word narrowing, magnitudes, sign flags, special cases.
// Narrowing exists only when EX_DIV_WORD_EN is defined.
module ex_div_opprep
    import ex_div_iter_pkg::*;
(
    input  logic            signed_i,
    input  logic            rem_i,
`ifdef EX_DIV_WORD_EN
    input  logic            word_i,
`endif
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output div_prep_t       prep_o
);

    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] min_val;
    logic            sa;
    logic            sb;
    logic            div_zero;
    logic            ovf;

    always_comb begin
        a       = src1_i;
        b       = src2_i;
        min_val = DMIN;
        prep_o  = '0;
`ifdef EX_DIV_WORD_EN
        prep_o.word = word_i;
        if (word_i) begin
            min_val = WMIN;
            if (signed_i) begin
                a = sext_word(src1_i);
                b = sext_word(src2_i);
            end else begin
                a = {{(XLEN-WLEN){1'b0}}, src1_i[WLEN-1:0]};
                b = {{(XLEN-WLEN){1'b0}}, src2_i[WLEN-1:0]};
            end
        end
`endif
        sa       = signed_i & a[XLEN-1];
        sb       = signed_i & b[XLEN-1];
        div_zero = (b == ZERO_DWORD);
        ovf      = signed_i && (a == min_val) && (&b);

        prep_o.abs_a   = sa ? -a : a;
        prep_o.abs_b   = sb ? -b : b;
        prep_o.q_neg   = sa ^ sb;
        prep_o.r_neg   = sa;
        prep_o.special = div_zero | ovf;

        // Zero divisor wins over overflow; both bypass the iteration.
        if (div_zero) begin
            if (!rem_i)
                prep_o.special_res = '1;
            else if (prep_o.word)
                prep_o.special_res = sext_word(a);
            else
                prep_o.special_res = a;
        end else if (ovf) begin
            prep_o.special_res = rem_i ? ZERO_DWORD : a;
        end
    end

endmodule

// File: rtl/ex_div_iter.sv
// Multi-cycle radix-2 restoring divider for RV64M in EX.
// Define EX_DIV_WORD_EN to enable the DIVW/DIVUW/REMW/REMUW path.
module ex_div_iter
    import ex_div_iter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_div_valid_i,
    output logic            ex_div_ready_o,
    input  logic            ex_div_signed_i,
    input  logic            ex_div_rem_i,
    input  logic            ex_div_inst_word_i,
    input  logic            ex_div_flush_i,
    input  logic [XLEN-1:0] ex_div_src1_i,
    input  logic [XLEN-1:0] ex_div_src2_i,
    output logic            ex_div_valid_o,
    input  logic            ex_div_ready_i,
    output logic [XLEN-1:0] ex_div_res_data_o
);

    div_prep_t        prep;
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  div_q, div_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             sel_rem_q, sel_rem_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  res_q, res_d;
`ifdef EX_DIV_WORD_EN
    logic             word_q, word_d;
`endif

    logic [XLEN:0]    rem_sh;
    logic [XLEN:0]    diff;
    logic [XLEN-1:0]  q_fix;
    logic [XLEN-1:0]  r_fix;
    logic [XLEN-1:0]  fix_res;
    logic             accept;

    ex_div_opprep u_opprep (
        .signed_i (ex_div_signed_i),
        .rem_i    (ex_div_rem_i),
`ifdef EX_DIV_WORD_EN
        .word_i   (ex_div_inst_word_i),
`endif
        .src1_i   (ex_div_src1_i),
        .src2_i   (ex_div_src2_i),
        .prep_o   (prep)
    );

`ifndef EX_DIV_WORD_EN
    logic unused_word;
    assign unused_word = ex_div_inst_word_i;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        sel_rem_d = sel_rem_q;
        ready_d   = ready_q;
        valid_d   = valid_q;
        res_d     = res_q;
`ifdef EX_DIV_WORD_EN
        word_d    = word_q;
`endif

        rem_sh  = {rem_q, quo_q[XLEN-1]};
        diff    = rem_sh - {1'b0, div_q};
        q_fix   = q_neg_q ? -quo_q : quo_q;
        r_fix   = r_neg_q ? -rem_q : rem_q;
        fix_res = sel_rem_q ? r_fix : q_fix;
`ifdef EX_DIV_WORD_EN
        if (word_q)
            fix_res = sext_word(fix_res);
`endif
        accept = ex_div_valid_i & ready_q & ~ex_div_flush_i;

        unique case (state_q)
            DIV_IDLE: begin
                if (accept) begin
                    ready_d   = 1'b0;
                    div_d     = prep.abs_b;
                    q_neg_d   = prep.q_neg;
                    r_neg_d   = prep.r_neg;
                    sel_rem_d = ex_div_rem_i;
`ifdef EX_DIV_WORD_EN
                    word_d    = prep.word;
`endif
                    if (prep.special) begin
                        res_d   = prep.special_res;
                        valid_d = 1'b1;
                        state_d = DIV_DONE;
                    end else begin
                        rem_d   = ZERO_DWORD;
                        // Word dividend sits in the top half so MSB-first shifting works.
                        quo_d   = prep.word ?
                                  {prep.abs_a[WLEN-1:0], {(XLEN-WLEN){1'b0}}} :
                                  prep.abs_a;
                        cnt_d   = prep.word ? CNT_WLAST : CNT_DLAST;
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == '0)
                    state_d = DIV_FIX;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            DIV_FIX: begin
                res_d   = fix_res;
                valid_d = 1'b1;
                state_d = DIV_DONE;
            end
            DIV_DONE: begin
                if (ex_div_ready_i) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        if (ex_div_flush_i) begin
            state_d = DIV_IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= ZERO_DWORD;
            quo_q     <= ZERO_DWORD;
            div_q     <= ZERO_DWORD;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            sel_rem_q <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            res_q     <= ZERO_DWORD;
`ifdef EX_DIV_WORD_EN
            word_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            sel_rem_q <= sel_rem_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            res_q     <= res_d;
`ifdef EX_DIV_WORD_EN
            word_q    <= word_d;
`endif
        end
    end

    assign ex_div_ready_o    = ready_q;
    assign ex_div_valid_o    = valid_q;
    assign ex_div_res_data_o = res_q;

endmodule

// File: tb/tb_ex_div_iter.sv
// Self-checking bench for ex_div_iter: directed spec cases plus random ops
// against an arithmetic reference model.
module tb_ex_div_iter;

`ifdef EX_DIV_WORD_EN
    localparam bit WORD_EN = 1'b1;
`else
    localparam bit WORD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, signed_i, rem_i, word_i, flush_i, ready_i;
    logic [63:0] src1, src2;
    logic        ready_o, valid_o;
    logic [63:0] res_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] last_res;

    always #5 clk = ~clk;

    ex_div_iter dut (
        .clk                (clk),
        .rst                (rst),
        .ex_div_valid_i     (valid_i),
        .ex_div_ready_o     (ready_o),
        .ex_div_signed_i    (signed_i),
        .ex_div_rem_i       (rem_i),
        .ex_div_inst_word_i (word_i),
        .ex_div_flush_i     (flush_i),
        .ex_div_src1_i      (src1),
        .ex_div_src2_i      (src2),
        .ex_div_valid_o     (valid_o),
        .ex_div_ready_i     (ready_i),
        .ex_div_res_data_o  (res_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_special(input bit sg, input bit wd,
                                      input logic [63:0] a,
                                      input logic [63:0] b);
        longint sa, sb;
        bit w = wd && WORD_EN;
        if (w) begin
            if (b[31:0] == 32'd0) return 1'b1;
            sa = longint'($signed(a[31:0]));
            sb = longint'($signed(b[31:0]));
            return sg && sa == -64'sd2147483648 && sb == -64'sd1;
        end
        if (b == 64'd0) return 1'b1;
        return sg && a == 64'h8000_0000_0000_0000 && b == '1;
    endfunction

    function automatic logic [63:0] model(input bit sg, input bit rm,
                                          input bit wd,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic [63:0] x, y, q, r, res;
        bit w = wd && WORD_EN;
        if (w) begin
            x = sg ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
            y = sg ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
        end else begin
            x = a;
            y = b;
        end
        if (y == 64'd0) begin
            q = '1;
            r = x;
        end else if (is_special(sg, wd, a, b)) begin
            q = x;
            r = 64'd0;
        end else if (sg) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
        res = rm ? r : q;
        if (w) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    task automatic run_op(input string tag, input bit sg, input bit rm,
                          input bit wd, input logic [63:0] a,
                          input logic [63:0] b, input int hold);
        logic [63:0] exp;
        int exp_lat, lat;
        exp = model(sg, rm, wd, a, b);
        if (is_special(sg, wd, a, b)) exp_lat = 1;
        else exp_lat = (wd && WORD_EN) ? 34 : 66;
        @(negedge clk);
        chk({tag, "_rdy"}, 64'(ready_o), 64'd1);
        valid_i = 1'b1; signed_i = sg; rem_i = rm; word_i = wd;
        src1 = a; src2 = b;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        signed_i = 1'($urandom); rem_i = 1'($urandom); word_i = 1'($urandom);
        src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        lat = 1;
        while (!valid_o && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, res_o, exp);
        last_res = res_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_res"}, res_o, exp);
            chk({tag, "_hold_vld"}, 64'(valid_o), 64'd1);
            chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd0);
        end
        ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready_i = 1'b0;
        chk({tag, "_drain_vld"}, 64'(valid_o), 64'd0);
        chk({tag, "_drain_rdy"}, 64'(ready_o), 64'd1);
    endtask

    function automatic logic [63:0] pick();
        unique case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return {$urandom, 32'h8000_0000};
            4: return 64'($urandom_range(1, 20));
            5: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        bit seen;
        rst = 1'b1; valid_i = 1'b0; signed_i = 1'b0; rem_i = 1'b0;
        word_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        src1 = '0; src2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_rdy", 64'(ready_o), 64'd1);
        chk("rst_vld", 64'(valid_o), 64'd0);
        chk("rst_res", res_o, 64'd0);

        run_op("div_100_m7", 1, 0, 0, 64'd100, -64'd7, 0);
        chk("div_100_m7_k", last_res, 64'hFFFF_FFFF_FFFF_FFF2);
        run_op("remu_max_10", 0, 1, 0, '1, 64'd10, 0);
        chk("remu_max_10_k", last_res, 64'd5);
        run_op("divw_ovf", 1, 0, 1, 64'h1234_5678_8000_0000,
               64'h0000_0000_FFFF_FFFF, 0);
        run_op("div_zero", 1, 0, 0, 64'd12345, 64'd0, 0);
        chk("div_zero_k", last_res, '1);
        run_op("remw_zero", 1, 1, 1, 64'h0000_0001_0000_0007, 64'd0, 0);
        run_op("divuw_big", 0, 0, 1, 64'h0000_0000_FFFF_FFFE, 64'd1, 0);
        run_op("div_ovf", 1, 0, 0, 64'h8000_0000_0000_0000, '1, 0);
        chk("div_ovf_k", last_res, 64'h8000_0000_0000_0000);
`ifdef EX_DIV_WORD_EN
        chk("divuw_big_k", last_res, last_res);
`endif

        // Flush in the middle of an iteration, with a competing request.
        @(negedge clk);
        valid_i = 1'b1; signed_i = 1'b1; rem_i = 1'b0; word_i = 1'b0;
        src1 = 64'd1000; src2 = 64'd3;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1; valid_i = 1'b1; src2 = 64'd0;
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flush_vld", 64'(valid_o), 64'd0);
        chk("flush_rdy", 64'(ready_o), 64'd1);
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        chk("flush_stale", 64'(seen), 64'd0);
        run_op("rem_m7_2", 1, 1, 0, -64'd7, 64'd2, 0);
        chk("rem_m7_2_k", last_res, '1);

        // Flush in IDLE must win over a simultaneous special-case request.
        @(negedge clk);
        flush_i = 1'b1; valid_i = 1'b1; src1 = 64'd9; src2 = 64'd0;
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flush_idle_rdy", 64'(ready_o), 64'd1);
        chk("flush_idle_vld", 64'(valid_o), 64'd0);

        run_op("hold5", 1, 0, 0, 64'd77777, 64'd13, 5);

        // Reset in the middle of an operation.
        @(negedge clk);
        valid_i = 1'b1; signed_i = 1'b0; rem_i = 1'b1;
        src1 = 64'd5555; src2 = 64'd7;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_rdy", 64'(ready_o), 64'd1);
        chk("mid_rst_vld", 64'(valid_o), 64'd0);
        chk("mid_rst_res", res_o, 64'd0);

        for (int n = 0; n < 40; n++) begin
            run_op("rand", 1'($urandom), 1'($urandom), 1'($urandom),
                   pick(), pick(), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
